// File: rtl/write_mat_stream_if.sv
// Streaming element bus: one matrix element per valid/ready handshake,
// tagged with its row/column position and an end-of-matrix marker.
interface write_mat_stream_if #(
  parameter int BITS = 64,
  parameter int RW   = 3,
  parameter int CW   = 3
);
  logic signed [BITS-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [RW-1:0]          out_row;
  logic [CW-1:0]          out_col;
  logic                   out_last;

  modport master (
    output out_data, out_valid, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/write_mat_stream.sv
// Captures a whole signed matrix on a start pulse and streams it out one
// element per handshake, in row-major (ORDER=0) or column-major (ORDER=1)
// order. Starts arriving while a stream is in flight are dropped.
module write_mat_stream #(
  parameter int ORDER  = 0,
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int BITS   = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic signed [BITS-1:0] in_matrix [SIZE_A][SIZE_B],
  output logic                   busy,
  output logic                   done,
  write_mat_stream_if.master     m_if
);
  localparam int RW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
  localparam int CW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
  localparam logic [RW-1:0] ROW_MAX = RW'(SIZE_A - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(SIZE_B - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                 state_q, state_d;
  logic [RW-1:0]          row_q, row_d;
  logic [CW-1:0]          col_q, col_d;
  logic signed [BITS-1:0] mem_q [SIZE_A][SIZE_B];

  logic capture;
  logic row_end;
  logic col_end;
  logic at_last;

  assign capture = (state_q == IDLE) && start;
  assign row_end = (row_q == ROW_MAX);
  assign col_end = (col_q == COL_MAX);
  assign at_last = row_end && col_end;

  // Matrix buffer: data only, loaded on an accepted start, no reset needed
  always_ff @(posedge clk) begin
    if (capture) begin
      mem_q <= in_matrix;
    end
  end

  // Control state and element indices
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Next-state and index advance; indices move only on a transfer
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          row_d   = '0;
          col_d   = '0;
        end
      end
      STREAM: begin
        if (m_if.out_ready) begin
          if (at_last) begin
            state_d = DONE;
            row_d   = '0;
            col_d   = '0;
          end else if (ORDER == 0) begin
            if (col_end) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            if (row_end) begin
              row_d = '0;
              col_d = col_q + 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m_if.out_valid = (state_q == STREAM);
  assign m_if.out_data  = m_if.out_valid ? mem_q[row_q][col_q] : '0;
  assign m_if.out_row   = row_q;
  assign m_if.out_col   = col_q;
  assign m_if.out_last  = m_if.out_valid && at_last;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
endmodule

// File: tb/tb_write_mat_stream.sv
// Bench for write_mat_stream: three instances (row-major 2x3, column-major
// 2x3, 1x1). Stimulus pushes expected elements into per-instance queues; a
// negedge monitor pops and compares on every handshake and checks that a
// stalled element stays put.
module tb_write_mat_stream;
  typedef struct {
    logic signed [15:0] d;
    int                 r;
    int                 c;
    logic               l;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic st  [3];
  logic rdy [3];
  logic bsy [3];
  logic dn  [3];
  logic vld [3];
  logic lst [3];
  logic signed [15:0] dat [3];
  logic [1:0] rw [3];
  logic [1:0] cl [3];

  logic signed [15:0] mat0 [2][3];
  logic signed [15:0] mat1 [2][3];
  logic signed [15:0] mat2 [1][1];

  write_mat_stream_if #(.BITS(16), .RW(1), .CW(2)) if0 ();
  write_mat_stream_if #(.BITS(16), .RW(1), .CW(2)) if1 ();
  write_mat_stream_if #(.BITS(16), .RW(1), .CW(1)) if2 ();

  write_mat_stream #(.ORDER(0), .SIZE_A(2), .SIZE_B(3), .BITS(16)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .in_matrix(mat0),
    .busy(bsy[0]), .done(dn[0]), .m_if(if0.master));
  write_mat_stream #(.ORDER(1), .SIZE_A(2), .SIZE_B(3), .BITS(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .in_matrix(mat1),
    .busy(bsy[1]), .done(dn[1]), .m_if(if1.master));
  write_mat_stream #(.ORDER(0), .SIZE_A(1), .SIZE_B(1), .BITS(16)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .in_matrix(mat2),
    .busy(bsy[2]), .done(dn[2]), .m_if(if2.master));

  assign if0.out_ready = rdy[0];
  assign if1.out_ready = rdy[1];
  assign if2.out_ready = rdy[2];
  assign vld[0] = if0.out_valid;
  assign vld[1] = if1.out_valid;
  assign vld[2] = if2.out_valid;
  assign lst[0] = if0.out_last;
  assign lst[1] = if1.out_last;
  assign lst[2] = if2.out_last;
  assign dat[0] = if0.out_data;
  assign dat[1] = if1.out_data;
  assign dat[2] = if2.out_data;
  assign rw[0]  = {1'b0, if0.out_row};
  assign rw[1]  = {1'b0, if1.out_row};
  assign rw[2]  = {1'b0, if2.out_row};
  assign cl[0]  = if0.out_col;
  assign cl[1]  = if1.out_col;
  assign cl[2]  = {1'b0, if2.out_col};

  // Hand-computed sequences for the matrix {1,-2,3},{4,5,-6}
  int rm_d [6] = '{1, -2, 3, 4, 5, -6};
  int rm_r [6] = '{0, 0, 0, 1, 1, 1};
  int rm_c [6] = '{0, 1, 2, 0, 1, 2};
  int cm_d [6] = '{1, 4, -2, 5, 3, -6};
  int cm_r [6] = '{0, 1, 0, 1, 0, 1};
  int cm_c [6] = '{0, 0, 1, 1, 2, 2};

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int nvec = 0;
  int nerr = 0;
  int pops [3] = '{0, 0, 0};
  logic held [3] = '{1'b0, 1'b0, 1'b0};
  logic signed [15:0] hd [3];
  logic [1:0] hr [3];
  logic [1:0] hc [3];
  logic hl [3];

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int qsz(input int s);
    case (s)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int s, input int d, input int r, input int c,
                       input logic l);
    exp_t e;
    e.d = 16'(d);
    e.r = r;
    e.c = c;
    e.l = l;
    case (s)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int s, output exp_t e);
    case (s)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic mon(input int s);
    exp_t e;
    if (!rst_n) begin
      held[s] = 1'b0;
      return;
    end
    if (held[s]) begin
      chk($sformatf("u%0d_hold_valid", s), vld[s], 1);
      chk($sformatf("u%0d_hold_data", s), dat[s], hd[s]);
      chk($sformatf("u%0d_hold_row", s), rw[s], hr[s]);
      chk($sformatf("u%0d_hold_col", s), cl[s], hc[s]);
      chk($sformatf("u%0d_hold_last", s), lst[s], hl[s]);
    end
    if (vld[s] && rdy[s]) begin
      if (qsz(s) == 0) begin
        nvec++;
        nerr++;
        $display("FAIL u%0d_unexpected_xfer: got data %0d, required no transfer at %0t",
                 s, dat[s], $time);
      end else begin
        qpop(s, e);
        pops[s]++;
        chk($sformatf("u%0d_data", s), dat[s], e.d);
        chk($sformatf("u%0d_row", s), rw[s], e.r);
        chk($sformatf("u%0d_col", s), cl[s], e.c);
        chk($sformatf("u%0d_last", s), lst[s], e.l);
      end
    end
    held[s] = vld[s] && !rdy[s];
    hd[s] = dat[s];
    hr[s] = rw[s];
    hc[s] = cl[s];
    hl[s] = lst[s];
  endtask

  // Scoreboard monitor, sampling away from the active edge
  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) mon(s);
  end

  task automatic chk_idle(input int s, input string tag);
    chk($sformatf("%s_u%0d_valid", tag, s), vld[s], 0);
    chk($sformatf("%s_u%0d_busy", tag, s), bsy[s], 0);
    chk($sformatf("%s_u%0d_done", tag, s), dn[s], 0);
    chk($sformatf("%s_u%0d_last", tag, s), lst[s], 0);
    chk($sformatf("%s_u%0d_data", tag, s), dat[s], 0);
    chk($sformatf("%s_u%0d_row", tag, s), rw[s], 0);
    chk($sformatf("%s_u%0d_col", tag, s), cl[s], 0);
  endtask

  // Called at posedge+1; leaves the caller one cycle after the start edge
  task automatic pulse_start(input int s);
    st[s] = 1'b1;
    @(posedge clk); #1;
    st[s] = 1'b0;
  endtask

  task automatic done_then_idle(input int s, input string tag);
    chk($sformatf("%s_done", tag), dn[s], 1);
    chk($sformatf("%s_done_busy", tag), bsy[s], 1);
    chk($sformatf("%s_done_valid", tag), vld[s], 0);
    chk($sformatf("%s_done_last", tag), lst[s], 0);
    @(posedge clk); #1;
    chk($sformatf("%s_idle_done", tag), dn[s], 0);
    chk($sformatf("%s_idle_busy", tag), bsy[s], 0);
    chk($sformatf("%s_queue_empty", tag), qsz(s), 0);
  endtask

  // Full-rate stream: n elements, done exactly n cycles after first element
  task automatic run_exact(input int s, input int n, input string tag);
    pulse_start(s);
    chk($sformatf("%s_busy_after_start", tag), bsy[s], 1);
    chk($sformatf("%s_valid_after_start", tag), vld[s], 1);
    repeat (n) begin
      @(posedge clk); #1;
    end
    done_then_idle(s, tag);
  endtask

  task automatic wait_done(input int s, input int budget, input string tag);
    int n = 0;
    while (!dn[s] && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    done_then_idle(s, tag);
  endtask

  task automatic push_rm(input int s);
    for (int i = 0; i < 6; i++) qpush(s, rm_d[i], rm_r[i], rm_c[i], i == 5);
  endtask

  task automatic load_mat0(input logic signed [15:0] fill, input logic use_fill);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        mat0[r][c] = use_fill ? fill : 16'(rm_d[r*3 + c]);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hold;
    int base;
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      st[s]  = 1'b0;
      rdy[s] = 1'b1;
    end
    load_mat0(16'sd0, 1'b0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        mat1[r][c] = 16'(rm_d[r*3 + c]);
    mat2[0][0] = -16'sd1;

    #3;
    for (int s = 0; s < 3; s++) chk_idle(s, "reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Row-major, full rate
    push_rm(0);
    run_exact(0, 6, "rowmaj");

    // Column-major, same matrix
    for (int i = 0; i < 6; i++) qpush(1, cm_d[i], cm_r[i], cm_c[i], i == 5);
    run_exact(1, 6, "colmaj");

    // Backpressure: alternate ready, plus a 5-cycle stall on element 3
    rdy[0] = 1'b0;
    push_rm(0);
    base = pops[0];
    hold = 0;
    pulse_start(0);
    for (int k = 0; k < 100 && !dn[0]; k++) begin
      if (pops[0] - base == 2 && hold < 5) begin
        rdy[0] = 1'b0;
        hold++;
      end else begin
        rdy[0] = k[0];
      end
      @(posedge clk); #1;
    end
    chk("bp_transfers", pops[0] - base, 6);
    done_then_idle(0, "bp");
    rdy[0] = 1'b1;

    // Start while busy is ignored; a later start captures the new matrix
    push_rm(0);
    pulse_start(0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    load_mat0(16'sh7FFF, 1'b1);
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    wait_done(0, 20, "busy_start");
    for (int i = 0; i < 6; i++) qpush(0, 32'h7FFF, rm_r[i], rm_c[i], i == 5);
    run_exact(0, 6, "restart");

    // Asynchronous reset during element 2
    load_mat0(16'sd0, 1'b0);
    qpush(0, 1, 0, 0, 1'b0);
    pulse_start(0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", vld[0], 0);
    chk("midrst_busy", bsy[0], 0);
    chk("midrst_done", dn[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_queue_empty", qsz(0), 0);
    @(posedge clk); #1;
    push_rm(0);
    run_exact(0, 6, "after_rst");

    // 1x1 matrix holding -1
    qpush(2, -1, 0, 0, 1'b1);
    run_exact(2, 1, "one");

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
